// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Default tuning values for the arbiter.
    localparam int unsigned STARVE_LIMIT_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Counter widths that cover the full legal parameter ranges (1..15 and 2..255).
    localparam int unsigned STARVE_CNT_W = 4;
    localparam int unsigned TO_CNT_W     = 8;

    // Raw 2-bit state encodings.
    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_BUSY_I = 2'd1;
    localparam logic [1:0] ENC_BUSY_D = 2'd2;
    localparam logic [1:0] ENC_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_BUSY_I = ENC_BUSY_I,
        ST_BUSY_D = ENC_BUSY_D,
        ST_RESP   = ENC_RESP
    } arb_state_e;

    // Completion data handed back to a requester: writes return zero.
    function automatic logic [31:0] resp_data(input logic we, input logic [31:0] rdata);
        return we ? 32'h0 : rdata;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Clear has priority over increment; the count sticks at MAX_V.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_V)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch and data ports.
// Data wins by default; a starvation counter forces a fetch grant and a watchdog aborts
// accesses the memory never acknowledges.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = STARVE_LIMIT_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // Instruction-fetch port
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic [31:0] o_inst_rdata,
    output logic        o_inst_ready,
    // Data port
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_sign_mask,
    output logic [31:0] o_data_rdata,
    output logic        o_data_ready,
    // Unified memory
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_sign_mask,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    // Pipeline status
    output logic        o_cpu_stall,
    output logic        o_bus_error
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [TO_CNT_W-1:0]     TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e  r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_sign_mask;
    logic [31:0] r_inst_rdata;
    logic        r_inst_ready;
    logic [31:0] r_data_rdata;
    logic        r_data_ready;
    logic        r_bus_error;

    logic [STARVE_CNT_W-1:0] w_starve_cnt;
    logic [TO_CNT_W-1:0]     w_to_cnt;
    logic                    w_idle;
    logic                    w_busy;
    logic                    w_grant_d;
    logic                    w_grant_i;
    logic                    w_grant;
    logic                    w_timeout;
    logic                    w_starve_clr;
    logic                    w_starve_inc;
    logic                    w_to_inc;

    // Grant selection, watchdog expiry and counter controls.
    always_comb begin
        w_idle       = (r_state == ST_IDLE);
        w_busy       = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
        w_grant_d    = w_idle && i_data_req && ((w_starve_cnt < STARVE_MAX) || !i_inst_req);
        w_grant_i    = w_idle && !w_grant_d && i_inst_req;
        w_grant      = w_grant_d || w_grant_i;
        // An ack in the expiry cycle still completes the access normally.
        w_timeout    = w_busy && !i_mem_ack && (w_to_cnt == TO_LAST);
        w_starve_inc = w_grant_d && i_inst_req;
        w_starve_clr = w_grant_i || (w_grant && !i_inst_req);
        w_to_inc     = w_busy && !i_mem_ack;
    end

    // Consecutive data wins while a fetch is waiting.
    sat_counter #(
        .WIDTH (STARVE_CNT_W),
        .MAX   (STARVE_LIMIT)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_clr   (w_starve_clr),
        .i_inc   (w_starve_inc),
        .o_count (w_starve_cnt)
    );

    // Cycles spent waiting for the memory in the current access.
    sat_counter #(
        .WIDTH (TO_CNT_W),
        .MAX   (TIMEOUT_CYCLES - 1)
    ) u_to_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_reset),
        .i_clr   (w_grant),
        .i_inc   (w_to_inc),
        .o_count (w_to_cnt)
    );

    // Access sequencing with all memory and response outputs registered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_mem_req       <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_mem_sign_mask <= 4'h0;
            r_inst_rdata    <= 32'h0;
            r_inst_ready    <= 1'b0;
            r_data_rdata    <= 32'h0;
            r_data_ready    <= 1'b0;
            r_bus_error     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state         <= ST_BUSY_D;
                        r_mem_req       <= 1'b1;
                        r_mem_we        <= i_data_we;
                        r_mem_addr      <= i_data_addr;
                        r_mem_wdata     <= i_data_wdata;
                        r_mem_sign_mask <= i_data_sign_mask;
                    end else if (w_grant_i) begin
                        r_state         <= ST_BUSY_I;
                        r_mem_req       <= 1'b1;
                        r_mem_we        <= 1'b0;
                        r_mem_addr      <= i_inst_addr;
                        r_mem_wdata     <= 32'h0;
                        r_mem_sign_mask <= 4'h0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (i_mem_ack || w_timeout) begin
                        r_state   <= ST_RESP;
                        r_mem_req <= 1'b0;
                        if (r_state == ST_BUSY_I) begin
                            r_inst_ready <= 1'b1;
                            r_inst_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
                        end else begin
                            r_data_ready <= 1'b1;
                            r_data_rdata <= i_mem_ack ? resp_data(r_mem_we, i_mem_rdata)
                                                      : 32'h0;
                        end
                        if (!i_mem_ack) begin
                            r_bus_error <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_inst_ready <= 1'b0;
                    r_data_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req       = r_mem_req;
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_mem_sign_mask = r_mem_sign_mask;
    assign o_inst_rdata    = r_inst_rdata;
    assign o_inst_ready    = r_inst_ready;
    assign o_data_rdata    = r_data_rdata;
    assign o_data_ready    = r_data_ready;
    assign o_bus_error     = r_bus_error;
    assign o_cpu_stall     = (i_inst_req & ~r_inst_ready) | (i_data_req & ~r_data_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;
    localparam int NV = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_inst_req = 1'b0;
    logic [31:0] i_inst_addr = 32'h0;
    logic        i_data_req = 1'b0;
    logic        i_data_we = 1'b0;
    logic [31:0] i_data_addr = 32'h0;
    logic [31:0] i_data_wdata = 32'h0;
    logic [3:0]  i_data_mask = 4'h0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] o_inst_rdata, o_data_rdata, o_mem_addr, o_mem_wdata;
    logic        o_inst_ready, o_data_ready, o_mem_req, o_mem_we, o_cpu_stall, o_bus_error;
    logic [3:0]  o_mem_mask;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_inst_req       (i_inst_req),
        .i_inst_addr      (i_inst_addr),
        .o_inst_rdata     (o_inst_rdata),
        .o_inst_ready     (o_inst_ready),
        .i_data_req       (i_data_req),
        .i_data_we        (i_data_we),
        .i_data_addr      (i_data_addr),
        .i_data_wdata     (i_data_wdata),
        .i_data_sign_mask (i_data_mask),
        .o_data_rdata     (o_data_rdata),
        .o_data_ready     (o_data_ready),
        .o_mem_req        (o_mem_req),
        .o_mem_we         (o_mem_we),
        .o_mem_addr       (o_mem_addr),
        .o_mem_wdata      (o_mem_wdata),
        .o_mem_sign_mask  (o_mem_mask),
        .i_mem_rdata      (i_mem_rdata),
        .i_mem_ack        (i_mem_ack),
        .o_cpu_stall      (o_cpu_stall),
        .o_bus_error      (o_bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dm;
        logic        ack;
        logic [31:0] mrd;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_mwe;
        logic [31:0] e_mwd;
        logic [3:0]  e_mm;
        logic        e_ir;
        logic [31:0] e_ird;
        logic        e_dr;
        logic [31:0] e_drd;
        logic        e_stall;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm,
        input logic ack, input logic [31:0] mrd,
        input logic emr, input logic [31:0] ema, input logic emwe, input logic [31:0] emwd,
        input logic [3:0] emm, input logic eir, input logic [31:0] eird,
        input logic edr, input logic [31:0] edrd, input logic est);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dm = dm;
        v.ack = ack; v.mrd = mrd; v.e_mreq = emr; v.e_maddr = ema; v.e_mwe = emwe;
        v.e_mwd = emwd; v.e_mm = emm; v.e_ir = eir; v.e_ird = eird; v.e_dr = edr;
        v.e_drd = edrd; v.e_stall = est;
        return v;
    endfunction

    // Drives zero requests, answers any pending memory request at once, counts ready pulses.
    task automatic drain(input int n, output int n_ir, output int n_dr);
        n_ir = 0;
        n_dr = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_inst_req = 1'b0;
            i_data_req = 1'b0;
            i_mem_ack  = o_mem_req;
            #4;
            n_ir += int'(o_inst_ready);
            n_dr += int'(o_data_ready);
        end
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
    endtask

    // Reference-model state (transaction view of the shared port).
    int          m_port, m_age, m_ackat, m_resp, m_starve;
    logic        m_berr, m_we;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic [3:0]  m_mask;

    initial begin
        int          gk[$];
        int          exp_kind[10];
        int          n_ir, n_dr, busy_cyc, held_ok, seen;
        logic        prev_req, i_done, d_done, e_stall;
        logic [31:0] got_rd;
        logic        got_be;

        exp_kind = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        //                 ir    ia        dr    we    da         wd           dm
        //                 ack   mrd       emr   ema        emwe  emwd        emm
        //                 eir   eird      edr   edrd       stall
        vecs[0]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[1]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h13,
                      1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[2]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h13, 1'b0, 32'h0, 1'b0);
        vecs[3]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs[4]  = mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[5]  = mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                      1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[9]  = mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1);
        vecs[10] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[11] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h93,
                      1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[12] = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 32'h93, 1'b0, 32'h0, 1'b0);
        vecs[13] = vecs[3];
        vecs[14] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[15] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0,
                      1'b1, 32'h40, 1'b1, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[16] = vecs[15];
        vecs[17] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b0011, 1'b1, 32'hFFFFFFFF,
                      1'b1, 32'h40, 1'b1, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        vecs[18] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b0011, 1'b0, 32'h0,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        vecs[19] = vecs[3];
        vecs[20] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h12345678,
                      1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        vecs[21] = vecs[3];

        // Reset state
        @(negedge clk);
        chk("reset mem_req", o_mem_req, 0);
        chk("reset mem_addr", o_mem_addr, 0);
        chk("reset inst_ready", o_inst_ready, 0);
        chk("reset data_ready", o_data_ready, 0);
        chk("reset bus_error", o_bus_error, 0);
        chk("reset data_rdata", o_data_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            i_inst_req = vecs[i].ir;   i_inst_addr = vecs[i].ia;
            i_data_req = vecs[i].dr;   i_data_we = vecs[i].dwe;  i_data_addr = vecs[i].da;
            i_data_wdata = vecs[i].dwd; i_data_mask = vecs[i].dm;
            i_mem_ack = vecs[i].ack;   i_mem_rdata = vecs[i].mrd;
            #4;
            chk($sformatf("vec%0d mem_req", i), o_mem_req, vecs[i].e_mreq);
            if (vecs[i].e_mreq) begin
                chk($sformatf("vec%0d mem_addr", i), o_mem_addr, vecs[i].e_maddr);
                chk($sformatf("vec%0d mem_we", i), o_mem_we, vecs[i].e_mwe);
                chk($sformatf("vec%0d mem_wdata", i), o_mem_wdata, vecs[i].e_mwd);
                chk($sformatf("vec%0d mem_mask", i), o_mem_mask, vecs[i].e_mm);
            end
            chk($sformatf("vec%0d inst_ready", i), o_inst_ready, vecs[i].e_ir);
            if (vecs[i].e_ir) chk($sformatf("vec%0d inst_rdata", i), o_inst_rdata, vecs[i].e_ird);
            chk($sformatf("vec%0d data_ready", i), o_data_ready, vecs[i].e_dr);
            if (vecs[i].e_dr) chk($sformatf("vec%0d data_rdata", i), o_data_rdata, vecs[i].e_drd);
            chk($sformatf("vec%0d cpu_stall", i), o_cpu_stall, vecs[i].e_stall);
            chk($sformatf("vec%0d bus_error", i), o_bus_error, 0);
        end

        // Starvation: both ports requesting continuously, zero-wait memory
        @(posedge clk); #1;
        i_inst_req = 1'b1; i_inst_addr = 32'h300;
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h2000;
        i_data_wdata = 32'h0; i_data_mask = 4'h0; i_mem_ack = 1'b0;
        prev_req = 1'b0;
        for (int c = 0; c < 80 && gk.size() < 10; c++) begin
            #4;
            if (o_mem_req && !prev_req) gk.push_back(int'(o_mem_addr >= 32'h2000));
            prev_req = o_mem_req;
            i_done = o_inst_ready;
            d_done = o_data_ready;
            if (gk.size() < 10) begin
                @(posedge clk); #1;
                i_mem_ack = o_mem_req;
                i_mem_rdata = $urandom;
                if (d_done) i_data_addr = i_data_addr + 32'h4;
                if (i_done) i_inst_addr = i_inst_addr + 32'h4;
            end
        end
        chk("starve grant count", gk.size(), 10);
        for (int g = 0; g < gk.size(); g++) chk($sformatf("starve grant%0d kind", g), gk[g], exp_kind[g]);
        // The fetch granted last is abandoned by the requester yet must still complete.
        drain(5, n_ir, n_dr);
        chk("dropped fetch still completes", n_ir, 1);

        // Timeout: write with no ack
        i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 32'h80;
        i_data_wdata = 32'h11223344; i_data_mask = 4'hF; i_mem_ack = 1'b0;
        busy_cyc = 0; held_ok = 0; seen = 0; got_rd = 32'hX; got_be = 1'b0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            #4;
            if (o_mem_req) begin
                busy_cyc++;
                if (o_mem_we && o_mem_addr == 32'h80 && o_mem_wdata == 32'h11223344 &&
                    o_mem_mask == 4'hF) held_ok++;
            end
            if (o_data_ready) begin
                seen = 1; got_rd = o_data_rdata; got_be = o_bus_error;
            end
            @(posedge clk); #1;
            if (seen != 0) i_data_req = 1'b0;
        end
        chk("timeout busy cycles", busy_cyc, TO);
        chk("timeout outputs held", held_ok, TO);
        chk("timeout ready seen", seen, 1);
        chk("timeout rdata", got_rd, 0);
        chk("timeout bus_error", got_be, 1);

        // Successful fetch afterwards: bus_error stays set
        i_inst_req = 1'b1; i_inst_addr = 32'h3C0; seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            #4;
            if (o_inst_ready) begin seen = 1; got_rd = o_inst_rdata; end
            @(posedge clk); #1;
            i_mem_ack = o_mem_req; i_mem_rdata = 32'hCAFE0001;
            if (seen != 0) i_inst_req = 1'b0;
        end
        i_mem_ack = 1'b0;
        chk("post-timeout fetch seen", seen, 1);
        chk("post-timeout fetch rdata", got_rd, 32'hCAFE0001);
        chk("bus_error sticky", o_bus_error, 1);

        // Reset in the middle of a data access
        i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 32'h500;
        i_inst_req = 1'b1; i_inst_addr = 32'h600; i_mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre-reset mem_req", o_mem_req, 1);
        chk("pre-reset mem_addr", o_mem_addr, 32'h500);
        rst = 1'b1;
        #1;
        chk("async reset mem_req", o_mem_req, 0);
        chk("async reset mem_addr", o_mem_addr, 0);
        chk("async reset bus_error", o_bus_error, 0);
        chk("async reset ready", {o_inst_ready, o_data_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0; i_data_req = 1'b0;
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
        #4;
        chk("late ack idle mem_req", o_mem_req, 0);
        chk("late ack idle ready", {o_inst_ready, o_data_ready}, 0);
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        #4;
        chk("after reset grant mem_req", o_mem_req, 1);
        chk("after reset grant addr", o_mem_addr, 32'h600);
        chk("after reset no ready", o_inst_ready, 0);
        @(posedge clk); #1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h60000001;
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        #4;
        chk("after reset fetch ready", o_inst_ready, 1);
        chk("after reset fetch rdata", o_inst_rdata, 32'h60000001);

        // Randomised traffic against the transaction model
        @(posedge clk); #1;
        rst = 1'b1; i_inst_req = 1'b0; i_data_req = 1'b0; i_mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_port = 0; m_age = 0; m_ackat = -1; m_resp = 0; m_starve = 0; m_berr = 1'b0;
        m_we = 1'b0; m_rdata = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_mask = 4'h0;
        i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (!i_inst_req || i_done) begin
                i_inst_req = ($urandom_range(0, 99) < 60);
                i_inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!i_data_req || d_done) begin
                i_data_req = ($urandom_range(0, 99) < 55);
                i_data_we = 1'($urandom_range(0, 1));
                i_data_addr = $urandom;
                i_data_wdata = $urandom;
                i_data_mask = 4'($urandom_range(0, 15));
            end
            i_mem_rdata = $urandom;
            if (m_port != 0) i_mem_ack = (m_age == m_ackat);
            else             i_mem_ack = ($urandom_range(0, 3) == 0);
            #4;
            chk("rnd mem_req", o_mem_req, (m_port != 0));
            if (m_port != 0) begin
                chk("rnd mem_addr", o_mem_addr, m_addr);
                chk("rnd mem_we", o_mem_we, m_we);
                chk("rnd mem_wdata", o_mem_wdata, m_wdata);
                chk("rnd mem_mask", o_mem_mask, m_mask);
            end
            chk("rnd inst_ready", o_inst_ready, (m_resp == 1));
            chk("rnd data_ready", o_data_ready, (m_resp == 2));
            if (m_resp == 1) chk("rnd inst_rdata", o_inst_rdata, m_rdata);
            if (m_resp == 2) chk("rnd data_rdata", o_data_rdata, m_rdata);
            chk("rnd bus_error", o_bus_error, m_berr);
            e_stall = (i_inst_req && m_resp != 1) || (i_data_req && m_resp != 2);
            chk("rnd cpu_stall", o_cpu_stall, e_stall);
            i_done = (m_resp == 1);
            d_done = (m_resp == 2);
            // Advance the model to the next cycle
            if (m_resp != 0) begin
                m_resp = 0;
            end else if (m_port != 0) begin
                if (i_mem_ack) begin
                    m_resp = m_port;
                    m_rdata = (m_port == 2 && m_we) ? 32'h0 : i_mem_rdata;
                    m_port = 0;
                end else if (m_age == TO - 1) begin
                    m_resp = m_port; m_rdata = 32'h0; m_berr = 1'b1; m_port = 0;
                end else begin
                    m_age++;
                end
            end else begin
                if (i_data_req && (m_starve < SL || !i_inst_req)) begin
                    m_port = 2; m_we = i_data_we; m_addr = i_data_addr;
                    m_wdata = i_data_wdata; m_mask = i_data_mask;
                    m_starve = i_inst_req ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
                end else if (i_inst_req) begin
                    m_port = 1; m_we = 1'b0; m_addr = i_inst_addr;
                    m_wdata = 32'h0; m_mask = 4'h0; m_starve = 0;
                end
                if (m_port != 0) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    m_age = 0;
                    if (r < 55)      m_ackat = int'($urandom_range(0, 3));
                    else if (r < 70) m_ackat = int'($urandom_range(4, TO - 2));
                    else if (r < 88) m_ackat = TO - 1;
                    else             m_ackat = -1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
